// File: rtl/uart_fifo.sv
// uart_fifo - parametrised synchronous byte FIFO with a first-word-fall-through read side.
// It replaces the single-register UART holding stage and absorbs bursts of up to DEPTH words.
//
// Parameters: DATA_W (word width), DEPTH (entries, power of two, >=2),
//             AF_LEVEL (almost_full threshold, 1..DEPTH)
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   wr_en        write request
//   wr_data      word to write
//   full         count == DEPTH
//   almost_full  count >= AF_LEVEL
//   rd_en        pop request
//   rd_data      head word, zero when empty
//   rd_valid     FIFO non-empty
//   count        occupancy 0..DEPTH
// Optional build macro UART_FIFO_OVF_EN adds the following ports:
//   ovf_clr      clears the sticky overflow flag
//   overflow     sticky flag, set when a write is dropped on a full FIFO
module uart_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count
`ifdef UART_FIFO_OVF_EN
  ,
  input  logic                     ovf_clr,
  output logic                     overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  // Status flags decode the registered occupancy only, never the request inputs.
  assign full        = (count == CW'(DEPTH));
  assign rd_valid    = (count != '0);
  assign almost_full = (count >= CW'(AF_LEVEL));

  // A pop frees a slot in the same edge, so a full FIFO still takes a write alongside a pop.
  // An empty FIFO ignores the pop even if a write lands in the same edge (no bypass).
  assign rd_acc = rd_en && rd_valid;
  assign wr_acc = wr_en && (!full || rd_acc);

  assign rd_data = rd_valid ? mem[rd_ptr] : '0;

  // Storage carries no reset; only the pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef UART_FIFO_OVF_EN
  // Set wins over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_en && !wr_acc) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              almost_full;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [2:0]        count;
`ifdef UART_FIFO_OVF_EN
  logic              ovf_clr;
  logic              overflow;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  uart_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .almost_full(almost_full),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .count      (count)
`ifdef UART_FIFO_OVF_EN
    ,
    .ovf_clr    (ovf_clr),
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus a sticky overflow bit.
  logic [DATA_W-1:0] q[$];
  logic              m_ovf = 1'b0;
  bit                chk_en = 1'b0;
  int                max_cnt = 0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      bit do_rd;
      bit do_wr;
      do_rd = rd_en && (q.size() > 0);
      do_wr = wr_en && ((q.size() < DEPTH) || do_rd);
      if (do_rd) void'(q.pop_front());
      if (do_wr) q.push_back(wr_data);
`ifdef UART_FIFO_OVF_EN
      if (wr_en && !do_wr) m_ovf = 1'b1;
      else if (ovf_clr)    m_ovf = 1'b0;
`endif
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("m_count", {29'b0, count}, q.size());
      chk("m_full", {31'b0, full}, {31'b0, q.size() == DEPTH});
      chk("m_rd_valid", {31'b0, rd_valid}, {31'b0, q.size() != 0});
      chk("m_almost_full", {31'b0, almost_full}, {31'b0, q.size() >= AF_LEVEL});
      chk("m_rd_data", {24'b0, rd_data}, (q.size() != 0) ? {24'b0, q[0]} : 32'h0);
`ifdef UART_FIFO_OVF_EN
      chk("m_overflow", {31'b0, overflow}, {31'b0, m_ovf});
`endif
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
  end

  task automatic cyc(input logic wr, input logic [7:0] d, input logic rd);
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    chk(name, {24'b0, rd_data}, {24'b0, exp});
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fill [4];
    fill[0] = 8'hA1; fill[1] = 8'hA2; fill[2] = 8'hA3; fill[3] = 8'hA4;
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
`ifdef UART_FIFO_OVF_EN
    ovf_clr = 1'b0;
`endif
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_rd_data", {24'b0, rd_data}, 32'd0);
    chk("rst_full", {31'b0, full}, 32'd0);

    // Fill to full, no reads.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, fill[i], 1'b0);
      if (i == 0) chk("first_word", {24'b0, rd_data}, 32'hA1);
    end
    chk("fill_count", {29'b0, count}, 32'd4);
    chk("fill_full", {31'b0, full}, 32'd1);

    // Write into full FIFO: dropped.
    cyc(1'b1, 8'h55, 1'b0);
    chk("drop_count", {29'b0, count}, 32'd4);
`ifdef UART_FIFO_OVF_EN
    chk("ovf_set", {31'b0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    ovf_clr = 1'b0;
    chk("ovf_clr", {31'b0, overflow}, 32'd0);
`endif
    for (int i = 0; i < 4; i++) pop_expect("drain_drop", fill[i]);
    chk("empty_valid", {31'b0, rd_valid}, 32'd0);
    chk("empty_data", {24'b0, rd_data}, 32'd0);

    // Refill, then simultaneous write+pop while full.
    for (int i = 0; i < 4; i++) cyc(1'b1, fill[i], 1'b0);
    cyc(1'b1, 8'h66, 1'b1);
    chk("wr_rd_full_count", {29'b0, count}, 32'd4);
    chk("wr_rd_full_flag", {31'b0, full}, 32'd1);
    pop_expect("drain_wr_rd", 8'hA2);
    pop_expect("drain_wr_rd", 8'hA3);
    pop_expect("drain_wr_rd", 8'hA4);
    pop_expect("drain_wr_rd", 8'h66);
    chk("drain2_valid", {31'b0, rd_valid}, 32'd0);

    // Empty FIFO: read ignored, write lands.
    cyc(1'b1, 8'h77, 1'b1);
    chk("empty_wr_rd_count", {29'b0, count}, 32'd1);
    chk("empty_wr_rd_data", {24'b0, rd_data}, 32'h77);
    pop_expect("pop_77", 8'h77);

    // Wrap test: 10 words, at most 3 outstanding.
    max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 3) begin
        cyc(1'b1, 8'(i), 1'b0);
      end else begin
        chk("wrap_order", {24'b0, rd_data}, i - 3);
        cyc(1'b1, 8'(i), 1'b1);
      end
      if (i == 2) chk("wrap_af_at3", {31'b0, almost_full}, 32'd1);
      if (i == 1) chk("wrap_af_at2", {31'b0, almost_full}, 32'd0);
    end
    for (int i = 7; i < 10; i++) pop_expect("wrap_order", 8'(i));
    chk("wrap_max_count", max_cnt, 32'd3);

    // Reset with count=3 and a write in flight.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0);
    chk("pre_rst_count", {29'b0, count}, 32'd3);
    reset = 1'b1;
    cyc(1'b1, 8'h99, 1'b0);
    reset = 1'b0;
    wr_en = 1'b0;
    chk("rst2_count", {29'b0, count}, 32'd0);
    chk("rst2_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst2_full", {31'b0, full}, 32'd0);
    chk("rst2_data", {24'b0, rd_data}, 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
